instruc_loader: RTL and testbench

Byte-serial program loader that fills the CPU's instruction memory through its write port (wrEn/addr/wrData). It takes bytes from the board switches or a host byte stream and packs each group of four into one 32-bit instruction. It writes each instruction to sequential addresses starting at 0. When loading completes it signals done so the CPU can be started with a freshly loaded program instead of a hardcoded one.

---
 rtl/instruc_loader.sv | 149 ++++++++++++++
 tb/tb_instruc_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruc_loader.sv
// Byte-serial loader: packs 4 bytes little-endian per word and writes them to instruction memory from address 0.
// Latency: wrEn one cycle after the 4th byte edge; flush write one cycle after finish, done the cycle after that.
// Backpressure: none. Bytes are taken whenever LOAD is active and dropped otherwise. Optional checksum: INSTRUC_LOADER_CHECKSUM_EN.
module instruc_loader #(
    parameter int INSTRUC_SIZE = 32,
    parameter int ARG_SIZE     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    finish,
    input  logic                    byteValid,
    input  logic [7:0]              byteIn,
    input  logic                    ack,
    output logic                    wrEn,
    output logic [ARG_SIZE-1:0]     addr,
    output logic [INSTRUC_SIZE-1:0] wrData,
    output logic [ARG_SIZE:0]       count,
    output logic                    loading,
    output logic                    done,
    output logic                    full,
    output logic [7:0]              checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ARG_SIZE-1:0] LAST_ADDR = '1;

    state_t                  state, state_nxt;
    logic [ARG_SIZE-1:0]     ptr;
    logic [1:0]              byte_idx, idx_upd;
    logic [INSTRUC_SIZE-1:0] asm_word, asm_upd;
    logic                    accept, word_done, flush_wr, wr_go, clear;

    // Assembly view after the current byte lands in its lane
    always_comb begin
        asm_upd = asm_word;
        idx_upd = byte_idx;
        if (accept) begin
            asm_upd[{byte_idx, 3'b000} +: 8] = byteIn;
            idx_upd = byte_idx + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        word_done = 1'b0;
        flush_wr  = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    clear     = 1'b1;
                end
            end
            LOAD: begin
                accept    = byteValid;
                word_done = byteValid && (byte_idx == 2'd3);
                // A byte is absorbed before finish looks at the lane index
                if (word_done && (ptr == LAST_ADDR)) begin
                    state_nxt = DONE;
                end else if (finish) begin
                    if (idx_upd == 2'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FLUSH;
                        flush_wr  = 1'b1;
                    end
                end
            end
            FLUSH: state_nxt = DONE;
            DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    clear     = 1'b1;
                end else if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_go = word_done || flush_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            byte_idx <= 2'd0;
            asm_word <= '0;
            wrEn     <= 1'b0;
            addr     <= '0;
            wrData   <= '0;
            count    <= '0;
            loading  <= 1'b0;
            done     <= 1'b0;
            full     <= 1'b0;
        end else begin
            state   <= state_nxt;
            wrEn    <= wr_go;
            loading <= (state_nxt == LOAD) || (state_nxt == FLUSH);
            done    <= (state_nxt == DONE);
            if (clear) begin
                ptr      <= '0;
                byte_idx <= 2'd0;
                asm_word <= '0;
                count    <= '0;
                full     <= 1'b0;
            end else begin
                if (accept) begin
                    byte_idx <= idx_upd;
                    asm_word <= word_done ? '0 : asm_upd;
                end
                if (wr_go) begin
                    addr   <= ptr;
                    wrData <= asm_upd;
                    ptr    <= ptr + 1'b1;
                    count  <= count + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        full <= 1'b1;
                    end
                end
                // Unfilled lanes of the flushed word are already zero
                if (flush_wr) begin
                    byte_idx <= 2'd0;
                    asm_word <= '0;
                end
            end
        end
    end

`ifdef INSTRUC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= 8'h00;
        end else if (clear) begin
            checksum <= 8'h00;
        end else if (accept) begin
            checksum <= checksum ^ byteIn;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_instruc_loader.sv
// Bench for instruc_loader: a default-depth instance and a 4-word instance share the same byte stream.
module tb_instruc_loader;

`ifdef INSTRUC_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, finish, byteValid, ack;
    logic [7:0] byteIn;

    logic        a_wrEn, a_loading, a_done, a_full;
    logic [7:0]  a_addr, a_checksum;
    logic [31:0] a_wrData;
    logic [8:0]  a_count;

    logic        b_wrEn, b_loading, b_done, b_full;
    logic [1:0]  b_addr;
    logic [7:0]  b_checksum;
    logic [31:0] b_wrData;
    logic [2:0]  b_count;

    instruc_loader #(.INSTRUC_SIZE(32), .ARG_SIZE(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .byteValid(byteValid),
        .byteIn(byteIn), .ack(ack), .wrEn(a_wrEn), .addr(a_addr), .wrData(a_wrData),
        .count(a_count), .loading(a_loading), .done(a_done), .full(a_full), .checksum(a_checksum)
    );

    instruc_loader #(.INSTRUC_SIZE(32), .ARG_SIZE(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .byteValid(byteValid),
        .byteIn(byteIn), .ack(ack), .wrEn(b_wrEn), .addr(b_addr), .wrData(b_wrData),
        .count(b_count), .loading(b_loading), .done(b_done), .full(b_full), .checksum(b_checksum)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_w[$];
    bit          exp_full;
    logic [7:0]  exp_ck;
    logic [39:0] mon_a[$];
    logic [39:0] mon_b[$];

    always @(negedge clk) begin
        if (a_wrEn) mon_a.push_back({a_addr, a_wrData});
        if (b_wrEn) mon_b.push_back({6'b0, b_addr, b_wrData});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic st, input logic bv, input logic [7:0] b, input logic fin, input logic ak);
        start = st; byteValid = bv; byteIn = b; finish = fin; ack = ak;
        @(negedge clk);
    endtask

    task automatic put(input logic bv, input logic [7:0] b, input logic fin);
        drive(1'b0, bv, b, fin, 1'b0);
    endtask

    // Reference: accepted bytes are the first 4*cap of the stream, chunked little-endian, tail zero padded
    task automatic build_model(input int cap);
        int n;
        logic [31:0] w;
        n = stim.size();
        if (n > 4 * cap) n = 4 * cap;
        exp_w.delete();
        exp_ck = 8'h00;
        for (int i = 0; i < n; i += 4) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) if (i + j < n) w[8*j +: 8] = stim[i+j];
            exp_w.push_back(w);
        end
        if (CK_EN) for (int i = 0; i < n; i++) exp_ck ^= stim[i];
        exp_full = (exp_w.size() == cap);
    endtask

    task automatic cmp_dut(input string tag, input int cap, input bit is_b);
        logic [39:0] got[$];
        logic dn, fl, ld;
        logic [7:0] ck;
        int cnt;
        build_model(cap);
        if (is_b) begin
            got = mon_b; dn = b_done; fl = b_full; ld = b_loading; ck = b_checksum; cnt = int'(b_count);
        end else begin
            got = mon_a; dn = a_done; fl = a_full; ld = a_loading; ck = a_checksum; cnt = int'(a_count);
        end
        chk({tag, "_nwr"}, got.size(), exp_w.size());
        for (int i = 0; i < got.size() && i < exp_w.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got[i][39:32], i);
            chk($sformatf("%s_data%0d", tag, i), got[i][31:0], exp_w[i]);
        end
        chk({tag, "_done"}, dn, 1'b1);
        chk({tag, "_loading"}, ld, 1'b0);
        chk({tag, "_count"}, cnt, exp_w.size());
        chk({tag, "_full"}, fl, exp_full);
        chk({tag, "_cksum"}, ck, exp_ck);
    endtask

    task automatic run_load(input string tag, input bit gaps, input bit coinc);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        mon_a.delete();
        mon_b.delete();
        for (int i = 0; i < stim.size(); i++) begin
            put(1'b1, stim[i], coinc && (i == stim.size() - 1));
            if (gaps) repeat ($urandom_range(0, 2)) put(1'b0, 8'h00, 1'b0);
        end
        if (!coinc || stim.size() == 0) put(1'b0, 8'h00, 1'b1);
        repeat (3) put(1'b0, 8'h00, 1'b0);
        cmp_dut({tag, "_b"}, 4, 1'b1);
        cmp_dut({tag, "_a"}, 256, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk({tag, "_ack_done"}, {a_done, b_done}, 2'b00);
        chk({tag, "_ack_count"}, a_count, exp_w.size());
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_a_ctl"}, {a_wrEn, a_loading, a_done, a_full}, 4'b0);
        chk({tag, "_a_addr"}, a_addr, 8'h00);
        chk({tag, "_a_data"}, a_wrData, 32'h0);
        chk({tag, "_a_count"}, a_count, 9'h0);
        chk({tag, "_a_cksum"}, a_checksum, 8'h00);
        chk({tag, "_b_all"}, {b_wrEn, b_loading, b_done, b_full, b_addr, b_wrData, b_count, b_checksum}, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; finish = 1'b0; byteValid = 1'b0; byteIn = 8'h00; ack = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        // IDLE ignores bytes and finish
        put(1'b1, 8'h55, 1'b1);
        chk("idle_ignore", {a_wrEn, a_loading, a_done}, 3'b000);

        // Full word then finish on an empty lane index
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_loading", a_loading, 1'b1);
        put(1'b1, 8'h78, 1'b0);
        put(1'b1, 8'h56, 1'b0);
        put(1'b1, 8'h34, 1'b0);
        chk("t1_no_early_wr", a_wrEn, 1'b0);
        put(1'b1, 8'h12, 1'b0);
        chk("t1_wren", a_wrEn, 1'b1);
        chk("t1_addr", a_addr, 8'h00);
        chk("t1_data", a_wrData, 32'h12345678);
        put(1'b0, 8'h00, 1'b1);
        chk("t1_done", {a_done, a_wrEn}, 2'b10);
        put(1'b0, 8'h00, 1'b0);
        chk("t1_count", a_count, 9'd1);
        chk("t1_cksum", a_checksum, CK_EN ? 8'h08 : 8'h00);

        // Partial word flush
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        put(1'b1, 8'h11, 1'b0);
        put(1'b1, 8'h22, 1'b0);
        put(1'b0, 8'h00, 1'b1);
        chk("t3_flush_wr", {a_wrEn, a_loading, a_done}, 3'b110);
        chk("t3_flush_data", a_wrData, 32'h00002211);
        chk("t3_flush_addr", a_addr, 8'h00);
        put(1'b0, 8'h00, 1'b0);
        chk("t3_done", {a_wrEn, a_done}, 2'b01);
        chk("t3_count", a_count, 9'd1);

        // 4th byte coincident with finish goes straight to DONE
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        put(1'b1, 8'h01, 1'b0);
        put(1'b1, 8'h02, 1'b0);
        put(1'b1, 8'h03, 1'b0);
        put(1'b1, 8'h04, 1'b1);
        chk("t4_wr_done", {a_wrEn, a_done, a_loading}, 3'b110);
        chk("t4_data", a_wrData, 32'h04030201);
        put(1'b0, 8'h00, 1'b0);
        chk("t4_no_flush", {a_wrEn, a_done}, 2'b01);

        // Finish on an empty word, then start beats ack in DONE
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        put(1'b0, 8'h00, 1'b1);
        chk("t5_empty", {a_done, a_wrEn}, 2'b10);
        chk("t5_count", a_count, 9'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_start_wins", {a_loading, a_done}, 2'b10);
        put(1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_ack", {a_loading, a_done}, 2'b00);

        // Back-to-back bytes across a word boundary
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load("b2b", 1'b0, 1'b0);

        // Overfill the 4-word instance
        stim.delete();
        for (int i = 0; i < 17; i++) stim.push_back(8'(8'h10 + i));
        run_load("fill", 1'b0, 1'b0);

        // Reset in the middle of a word
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        mon_a.delete();
        mon_b.delete();
        put(1'b1, 8'hA1, 1'b0);
        put(1'b1, 8'hB2, 1'b0);
        reset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        put(1'b0, 8'h00, 1'b0);
        put(1'b0, 8'h00, 1'b0);
        chk("rst_mid_nowr", mon_a.size() + mon_b.size(), 0);
        reset = 1'b1;
        put(1'b0, 8'h00, 1'b0);
        stim = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_load("after_rst", 1'b0, 1'b0);

        // Randomised loads with gaps and coincident finish
        for (int s = 0; s < 12; s++) begin
            int n;
            bit gp, co;
            n = $urandom_range(0, 20);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom_range(0, 255)));
            gp = 1'($urandom_range(0, 1));
            co = 1'($urandom_range(0, 1)) && (n > 0);
            run_load($sformatf("rnd%0d", s), gp, co);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
